hazard_ctrl: RTL



---
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: RAW scoreboard, taken-transfer squash
// sequencing and saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter bit          WB_BYPASS    = 1'b1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic             id_rs1v,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs2v,
    input  logic [4:0]       id_rd,
    input  logic             id_rdv,
    input  logic             ex_taken,
    input  logic [4:0]       wb_rd,
    input  logic             wb_we,
    output logic             stall,
    output logic             jmp,
    output logic [31:0]      pending,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH
    } state_t;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic [3:0]       r_flush_left;
    logic [31:0]      r_pending;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic        w_hz1;
    logic        w_hz2;
    logic        w_hazard;
    logic        w_jmp;
    logic        w_stall;
    logic        w_issue;
    logic        w_clear;
    logic [31:0] w_pending_nxt;

    // A writeback landing this cycle satisfies the read when the register file writes through.
    assign w_hz1 = id_rs1v && (id_rs1 != 5'd0) && r_pending[id_rs1]
                   && !(WB_BYPASS && wb_we && (wb_rd == id_rs1));
    assign w_hz2 = id_rs2v && (id_rs2 != 5'd0) && r_pending[id_rs2]
                   && !(WB_BYPASS && wb_we && (wb_rd == id_rs2));
    assign w_hazard = w_hz1 || w_hz2;

    // Both outputs are held low during reset even though they are combinational.
    assign w_jmp   = !rst && (ex_taken || (r_state == FLUSH));
    assign w_stall = !rst && w_hazard && !w_jmp;

    assign w_issue = id_rdv && (id_rd != 5'd0) && !w_stall && !w_jmp;
    assign w_clear = wb_we && (wb_rd != 5'd0);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_clear) begin
            w_pending_nxt[wb_rd] = 1'b0;
        end
        // Set after clear: a new writer to the same register is still in flight.
        if (w_issue) begin
            w_pending_nxt[id_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= RUN;
            r_flush_left <= 4'd0;
            r_pending    <= 32'd0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_pending <= w_pending_nxt;

            if (ex_taken) begin
                if (FLUSH_CYCLES > 1) begin
                    r_state      <= FLUSH;
                    r_flush_left <= FLUSH_RELOAD;
                end else begin
                    r_state      <= RUN;
                    r_flush_left <= 4'd0;
                end
            end else if (r_state == FLUSH) begin
                if (r_flush_left == 4'd1) begin
                    r_state <= RUN;
                end
                r_flush_left <= r_flush_left - 4'd1;
            end else if (w_hazard) begin
                r_state <= STALL;
            end else begin
                r_state <= RUN;
            end

            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (ex_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign stall     = w_stall;
    assign jmp       = w_jmp;
    assign pending   = r_pending;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
